// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM encoding, legal oversampling ratios, voting helper.
// UART_RX_PARITY_EN adds the PARITY state to the encoding.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic prescale_legal(input int p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-sample majority voter around the bit centre.
// Emits the voted bit with a strobe on the third sample and a strobe on the last edge of the bit.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_run,
  input  logic                  i_rx,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  o_bit,
  output logic                  o_sample_stb,
  output logic                  o_bit_done
);

  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [PRESCALE_W-1:0] w_half;
  logic [PRESCALE_W-1:0] w_last;
  logic                  r_s0;
  logic                  r_s1;

  assign w_half = i_prescale >> 1;
  assign w_last = i_prescale - PRESCALE_W'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_edge_cnt <= '0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
    end else if (!i_run) begin
      r_edge_cnt <= '0;
    end else begin
      r_edge_cnt <= (r_edge_cnt == w_last) ? '0 : r_edge_cnt + PRESCALE_W'(1);
      if (r_edge_cnt == w_half - PRESCALE_W'(1)) r_s0 <= i_rx;
      if (r_edge_cnt == w_half)                  r_s1 <= i_rx;
    end
  end

  // Third sample is taken live so the vote is ready on the same edge count.
  assign o_bit        = majority3(r_s0, r_s1, i_rx);
  assign o_sample_stb = i_run && (r_edge_cnt == w_half + PRESCALE_W'(1));
  assign o_bit_done   = i_run && (r_edge_cnt == w_last);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/(parity)/stop framing, LSB first, registered output pulses.
// Define UART_RX_PARITY_EN to build in the parity state and PAR_ERR checker.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_sync1;
  logic                  r_sync2;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [BCW-1:0]        r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic                  r_data_valid;
  logic                  r_stp_err;
  logic                  w_bit;
  logic                  w_sample_stb;
  logic                  w_bit_done;
  logic                  w_start_go;
  logic                  w_par_fail;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RX_IN;
      r_sync2 <= r_sync1;
    end
  end

  uart_rx_sampler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_sampler (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_run       (r_state != ST_IDLE),
    .i_rx        (r_sync2),
    .i_prescale  (r_prescale),
    .o_bit       (w_bit),
    .o_sample_stb(w_sample_stb),
    .o_bit_done  (w_bit_done)
  );

  assign w_start_go = (r_state == ST_IDLE) && !r_sync2;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_en;
  logic r_par_typ;
  logic r_par_fail;
  logic r_par_err;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_par_fail <= 1'b0;
      r_par_err  <= 1'b0;
    end else begin
      r_par_err <= 1'b0;
      if (w_start_go) begin
        r_par_en   <= PAR_EN;
        r_par_typ  <= PAR_TYP;
        r_par_fail <= 1'b0;
      end
      if (r_state == ST_PARITY && w_sample_stb && (w_bit != ((^r_shift) ^ r_par_typ))) begin
        r_par_fail <= 1'b1;
        r_par_err  <= 1'b1;
      end
    end
  end

  assign w_par_fail = r_par_fail;
  assign PAR_ERR    = r_par_err;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = PAR_EN ^ PAR_TYP;
  assign w_par_fail   = 1'b0;
  assign PAR_ERR      = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_go) w_next_state = ST_START;
      ST_START: begin
        if (w_sample_stb && w_bit) w_next_state = ST_IDLE;
        else if (w_bit_done)       w_next_state = ST_DATA;
      end
      ST_DATA: begin
        if (w_bit_done && r_bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
          w_next_state = r_par_en ? ST_PARITY : ST_STOP;
`else
          w_next_state = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (w_bit_done) w_next_state = ST_STOP;
`endif
      // Leave at the stop sample point so an immediately following start bit is caught.
      ST_STOP:  if (w_sample_stb) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_prescale   <= PRESCALE_W'(PRESCALE_16);
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
      r_stp_err    <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_stp_err    <= 1'b0;
      if (w_start_go) begin
        // An out-of-range ratio falls back to 16 rather than running a malformed counter.
        r_prescale <= prescale_legal(int'(PRESCALE)) ? PRESCALE : PRESCALE_W'(PRESCALE_16);
        r_bit_cnt  <= '0;
      end
      if (r_state == ST_DATA) begin
        if (w_sample_stb) r_shift   <= {w_bit, r_shift[DATA_WIDTH-1:1]};
        if (w_bit_done)   r_bit_cnt <= r_bit_cnt + BCW'(1);
      end
      if (r_state == ST_STOP && w_sample_stb) begin
        r_stp_err <= !w_bit;
        if (w_bit && !w_par_fail) begin
          r_data_valid <= 1'b1;
          r_p_data     <= r_shift;
        end
      end
    end
  end

  assign P_DATA     = r_p_data;
  assign DATA_VALID = r_data_valid;
  assign STP_ERR    = r_stp_err;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected pulses, a monitor pops and compares.
// Expectations follow whether UART_RX_PARITY_EN is defined for the build.
module tb_uart_rx;

  localparam int DW = 8;
  localparam int PW = 6;
`ifdef UART_RX_PARITY_EN
  localparam bit PB = 1'b1;
`else
  localparam bit PB = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          RX_IN = 1'b1;
  logic [PW-1:0] PRESCALE = 6'd8;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID;
  logic          PAR_ERR;
  logic          STP_ERR;

  typedef struct {
    logic        dv;
    logic        pe;
    logic        se;
    logic [7:0]  data;
    string       name;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] last_data = 8'h00;

  uart_rx #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .PRESCALE  (PRESCALE),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_ERR   (PAR_ERR),
    .STP_ERR   (STP_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input string name, input logic dv, input logic pe, input logic se,
                           input logic [7:0] d);
    exp_t e;
    if (dv) last_data = d;
    e.dv = dv; e.pe = pe; e.se = se; e.data = last_data; e.name = name;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_bit(input logic b, input int p);
    RX_IN = b;
    repeat (p) @(negedge CLK);
  endtask

  // mangle: disturb the config inputs after the start bit; the frame must ignore it.
  task automatic send_frame(input logic [7:0] d, input int p, input logic par_on,
                            input logic par_bit, input logic stop_bit, input logic mangle);
    send_bit(1'b0, p);
    if (mangle) begin
      PRESCALE = 6'd8;
      PAR_EN   = ~PAR_EN;
    end
    for (int i = 0; i < 8; i++) send_bit(d[i], p);
    if (PB && par_on) send_bit(par_bit, p);
    send_bit(stop_bit, p);
    RX_IN = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (DATA_VALID || PAR_ERR || STP_ERR) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: dv=%b pe=%b se=%b p_data=0x%h, required no pulse",
                   DATA_VALID, PAR_ERR, STP_ERR, P_DATA);
        end else begin
          mon_e = sb.pop_front();
          check({mon_e.name, "_flags"}, {29'd0, DATA_VALID, PAR_ERR, STP_ERR},
                {29'd0, mon_e.dv, mon_e.pe, mon_e.se});
          check({mon_e.name, "_pdata"}, {24'd0, P_DATA}, {24'd0, mon_e.data});
          $display("txn %s: dv=%b pe=%b se=%b p_data=0x%h", mon_e.name,
                   DATA_VALID, PAR_ERR, STP_ERR, P_DATA);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d expected events pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("reset_pdata", {24'd0, P_DATA}, 32'h0);
    check("reset_dv", {31'd0, DATA_VALID}, 32'h0);
    check("reset_pe", {31'd0, PAR_ERR}, 32'h0);
    check("reset_se", {31'd0, STP_ERR}, 32'h0);
    RST = 1'b0;
    idle(5);

    PRESCALE = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    expect_ev("even_0x81_ok", 1'b1, 1'b0, 1'b0, 8'h81);
    send_frame(8'h81, 8, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(24);

    if (PB) expect_ev("even_0x81_par_err", 1'b0, 1'b1, 1'b0, 8'h00);
    else    expect_ev("even_0x81_no_par_build", 1'b1, 1'b0, 1'b0, 8'h81);
    send_frame(8'h81, 8, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(24);

    PRESCALE = 6'd16; PAR_EN = 1'b0;
    expect_ev("p16_0x3c_stp_err", 1'b0, 1'b0, 1'b1, 8'h00);
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(48);

    if (PB) begin
      PRESCALE = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
      expect_ev("both_errors", 1'b0, 1'b1, 1'b1, 8'h00);
      send_frame(8'h81, 8, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(24);
    end

    PRESCALE = 6'd8;
    RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    idle(40);

    PAR_EN = 1'b1; PAR_TYP = 1'b1;
    expect_ev("odd_b2b_0x0a", 1'b1, 1'b0, 1'b0, 8'h0A);
    expect_ev("odd_b2b_0x91", 1'b1, 1'b0, 1'b0, 8'h91);
    send_frame(8'h0A, 8, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(8'h91, 8, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(24);

    PRESCALE = 6'd32; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    expect_ev("p32_0xc3_cfg_held", 1'b1, 1'b0, 1'b0, 8'hC3);
    send_frame(8'hC3, 32, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(96);

    PRESCALE = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    send_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h55 >> i), 8);
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("async_rst_pdata", {24'd0, P_DATA}, 32'h0);
    check("async_rst_dv", {31'd0, DATA_VALID}, 32'h0);
    last_data = 8'h00;
    @(negedge CLK);
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    idle(20);

    expect_ev("after_rst_0xa5", 1'b1, 1'b0, 1'b0, 8'hA5);
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(24);

    for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge CLK);
    check("scoreboard_drained", sb.size(), 32'd0);
    check("final_pdata", {24'd0, P_DATA}, 32'h000000A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of payload bits per frame.
REQ-002 Parameter PRESCALE_W, default 6: width of the PRESCALE port.
REQ-003 CLK  input  1  receiver clock (oversampling clock); all state changes on rising edge.
REQ-004 RST  input  1  reset, asynchronous and active-high.
REQ-005 RX_IN  input  1  serial line, idle high, LSB-first frames.
REQ-006 PRESCALE  input  PRESCALE_W  oversampling ratio (CLK cycles per bit); legal values 8, 16, 32.
REQ-007 PAR_EN  input  1  1 = frame carries a parity bit.
REQ-008 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-009 P_DATA  output  DATA_WIDTH  last received payload.
REQ-010 DATA_VALID  output  1  one-cycle pulse when P_DATA holds a new error-free frame.
REQ-011 PAR_ERR  output  1  one-cycle pulse: parity mismatch in the current frame.
REQ-012 STP_ERR  output  1  one-cycle pulse: stop bit sampled low.

Function
REQ-013 RX_IN is passed through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-014 FSM states: IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PAR_EN=0.
REQ-015 IDLE -> START on a synchronized falling level (sample = 0); edge counter cleared to 0.
REQ-016 An edge counter runs 0..PRESCALE-1 per bit; a bit counter counts 0..DATA_WIDTH-1 in DATA.
REQ-017 Each bit value is the majority of 3 samples taken at edge counts PRESCALE/2-1, PRESCALE/2, PRESCALE/2+1.
REQ-018 START: sampled bit 1 -> glitch, return to IDLE with no output pulse; sampled 0 -> DATA at edge count PRESCALE-1.
REQ-019 DATA: sampled bits shift in LSB first; after bit DATA_WIDTH-1 -> PARITY (PAR_EN=1) or STOP.
REQ-020 PARITY: expected bit = XOR of payload (even) or its inverse (odd); mismatch raises PAR_ERR for one cycle at the cycle after the sample point.
REQ-021 STOP: decision taken at the majority sample point (not end of bit) so back-to-back frames are not missed; 0 -> STP_ERR pulse; then return to IDLE.
REQ-022 DATA_VALID pulses exactly one cycle, the cycle after the stop sample, only if stop = 1 and no parity error in this frame; P_DATA updates in the same cycle and holds until the next valid frame.
REQ-023 PAR_ERR and STP_ERR both pulse if both faults occur; DATA_VALID stays 0 on any error.
REQ-024 PRESCALE, PAR_EN, PAR_TYP are sampled at the IDLE->START transition and held for the frame; mid-frame changes have no effect.
REQ-025 A new start bit detected in IDLE directly after STOP begins a new frame with no dead cycle required.

Reset
REQ-026 RST asserted: FSM -> IDLE, counters 0, synchronizer flops 1, P_DATA 0, DATA_VALID/PAR_ERR/STP_ERR 0, effective immediately regardless of CLK.
REQ-027 RST asserted mid-frame discards the partial frame; no output pulse follows deassertion.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: parity state, checker and PAR_ERR logic are compiled in and behave per REQ-020.
REQ-029 Macro UART_RX_PARITY_EN undefined: PAR_EN and PAR_TYP are ignored, PARITY state is absent, PAR_ERR ties to 0; frame = start + data + stop.

Structure
REQ-030 Shared package holds the FSM state enum/encoding and the legal PRESCALE constants (8, 16, 32).
REQ-031 One sub-module, uart_rx_sampler: edge counter plus 3-sample majority voter, outputs sampled bit and bit-done strobe.

Verification
REQ-032 PRESCALE=8, PAR_EN=1, PAR_TYP=0, frame 0x81 (parity 0, stop 1) -> P_DATA=0x81, one DATA_VALID pulse, no errors.
REQ-033 Same config, 0x81 sent with parity bit 1 -> PAR_ERR pulse, DATA_VALID stays 0, P_DATA keeps previous value.
REQ-034 PRESCALE=16, PAR_EN=0, 0x3C with stop bit 0 -> STP_ERR pulse, no DATA_VALID.
REQ-035 RX_IN low for 2 CLK cycles then high, PRESCALE=8 -> FSM returns to IDLE, no output pulses.
REQ-036 PRESCALE=8, PAR_EN=1, PAR_TYP=1, back-to-back 0x0A then 0x91 with no idle gap -> two DATA_VALID pulses with P_DATA 0x0A then 0x91.
REQ-037 RST pulsed during DATA bit 4 of 0x55, then clean 0xA5 -> only one DATA_VALID pulse, P_DATA=0xA5.
